// File: rtl/div_rem_unit.sv
// rtl/div_rem_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    request pulse, sampled only while idle
//   op       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend rs1 operand, captured when start is accepted
//   divisor  rs2 operand, captured when start is accepted
//   busy     high from acceptance until the done pulse ends
//   done     one-cycle pulse, result valid while high
//   result   quotient or remainder; holds until the next completion
module div_rem_unit #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] CNT_INIT = CW'(n - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [n-1:0]  quo;      // holds |dividend| at start, quotient bits shift in at the LSB
  logic [n-1:0]  rem;
  logic [n-1:0]  dvs;      // |divisor|
  logic          rem_sel;  // op[1]: deliver remainder instead of quotient
  logic          neg_q;
  logic          neg_r;

  // Operand conditioning at acceptance
  logic          is_signed;
  logic          dvd_neg;
  logic          dvs_neg;
  logic [n-1:0]  dvd_abs;
  logic [n-1:0]  dvs_abs;
  logic          div_zero;
  logic          overflow;

  assign is_signed = ~op[0];
  assign dvd_neg   = is_signed & dividend[n-1];
  assign dvs_neg   = is_signed & divisor[n-1];
  // Negating the most negative value wraps back to itself, which read as
  // unsigned is exactly its magnitude.
  assign dvd_abs   = dvd_neg ? -dividend : dividend;
  assign dvs_abs   = dvs_neg ? -divisor  : divisor;
  assign div_zero  = (divisor == '0);
  assign overflow  = is_signed && (dividend == {1'b1, {(n-1){1'b0}}}) && (divisor == '1);

  // Restoring step on an n+1 bit datapath: the shifted remainder can reach
  // 2*|divisor|-1, so the sign of the n+1 bit difference is the compare.
  logic [n:0] rem_shift;
  logic [n:0] diff;
  logic       ge;

  assign rem_shift = {rem, quo[n-1]};
  assign diff      = rem_shift - {1'b0, dvs};
  assign ge        = ~diff[n];

  logic [n-1:0] q_fin;
  logic [n-1:0] r_fin;

  assign q_fin = neg_q ? -quo : quo;
  assign r_fin = neg_r ? -rem : rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      rem_sel <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            rem_sel <= op[1];
            cnt     <= CNT_INIT;
            if (div_zero) begin
              // Architectural results are final; suppress sign correction.
              quo   <= '1;
              rem   <= dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FINISH;
            end else if (overflow) begin
              quo   <= dividend;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FINISH;
            end else begin
              quo   <= dvd_abs;
              dvs   <= dvs_abs;
              rem   <= '0;
              neg_q <= dvd_neg ^ dvs_neg;
              neg_r <= dvd_neg;
              state <= CALC;
            end
          end
        end

        CALC: begin
          rem <= ge ? diff[n-1:0] : rem_shift[n-1:0];
          quo <= {quo[n-2:0], ge};
          if (cnt == '0) begin
            state <= FINISH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        FINISH: begin
          // Two edges here: the first registers the result and raises done,
          // the second drops done and returns to IDLE so start stays ignored
          // while done is visible.
          if (!done) begin
            result <= rem_sel ? r_fin : q_fin;
            done   <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_rem_unit.sv
// tb/tb_div_rem_unit.sv - directed self-checking bench for div_rem_unit
module tb_div_rem_unit;

  localparam int N = 32;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int WINDOW = 40;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int n_checks;
  int n_fail;

  div_rem_unit #(.n(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and watch WINDOW edges after the accepting edge.
  // lat is the edge index (acceptance = 0) after which done was first seen.
  task automatic do_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] res, output int lat, output int dcount,
                       output logic busy_acc, output logic busy_end);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    busy_acc = busy;
    lat = -1; dcount = 0; res = 'x;
    for (int i = 1; i <= WINDOW; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (lat < 0) begin
          lat = i;
          res = result;
        end
        dcount++;
      end
    end
    busy_end = busy;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_divu;
    logic [N-1:0] res;
    int lat, dc;
    logic ba, be;
    do_op(OP_DIVU, 32'd100, 32'd7, res, lat, dc, ba, be);
    n_checks++;
    if (res !== 32'd14) begin n_fail++; $display("FAIL divu_100_7: result=%h want %h", res, 32'd14); end
    n_checks++;
    if (lat !== N + 1) begin n_fail++; $display("FAIL divu_latency: done after edge %0d want %0d", lat, N + 1); end
    n_checks++;
    if (dc !== 1) begin n_fail++; $display("FAIL divu_done_width: done cycles=%0d want 1", dc); end
    n_checks++;
    if (ba !== 1'b1 || be !== 1'b0) begin n_fail++; $display("FAIL divu_busy: at_accept=%b at_end=%b want 1 0", ba, be); end
    do_op(OP_REMU, 32'd100, 32'd7, res, lat, dc, ba, be);
    n_checks++;
    if (res !== 32'd2 || lat !== N + 1) begin
      n_fail++; $display("FAIL remu_100_7: result=%h lat=%0d want %h lat %0d", res, lat, 32'd2, N + 1);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_no_done: busy/done cycles=%0d want 0", seen); end
  endtask

  task automatic test_signed;
    logic [1:0]   ops [6];
    logic [N-1:0] as  [6];
    logic [N-1:0] bs  [6];
    logic [N-1:0] exp [6];
    logic [N-1:0] res;
    int lat, dc;
    logic ba, be;
    ops[0] = OP_DIV; as[0] = -32'sd7; bs[0] = 32'd2;    exp[0] = 32'hFFFF_FFFD;
    ops[1] = OP_REM; as[1] = -32'sd7; bs[1] = 32'd2;    exp[1] = 32'hFFFF_FFFF;
    ops[2] = OP_DIV; as[2] = 32'd7;   bs[2] = -32'sd2;  exp[2] = 32'hFFFF_FFFD;
    ops[3] = OP_REM; as[3] = 32'd7;   bs[3] = -32'sd2;  exp[3] = 32'd1;
    ops[4] = OP_DIV; as[4] = -32'sd7; bs[4] = -32'sd2;  exp[4] = 32'd3;
    ops[5] = OP_REM; as[5] = -32'sd7; bs[5] = -32'sd2;  exp[5] = 32'hFFFF_FFFF;
    for (int k = 0; k < 6; k++) begin
      do_op(ops[k], as[k], bs[k], res, lat, dc, ba, be);
      n_checks++;
      if (res !== exp[k] || lat !== N + 1) begin
        n_fail++;
        $display("FAIL signed_%0d: op=%b %h/%h result=%h lat=%0d want %h lat %0d",
                 k, ops[k], as[k], bs[k], res, lat, exp[k], N + 1);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [N-1:0] res;
    int lat, dc;
    logic ba, be;
    do_op(OP_DIVU, 32'd5, 32'd0, res, lat, dc, ba, be);
    n_checks++;
    if (res !== 32'hFFFF_FFFF || lat !== 1 || dc !== 1) begin
      n_fail++; $display("FAIL divu_by_zero: result=%h lat=%0d done=%0d want ffffffff lat 1 done 1", res, lat, dc);
    end
    do_op(OP_REM, -32'sd5, 32'd0, res, lat, dc, ba, be);
    n_checks++;
    if (res !== 32'hFFFF_FFFB || lat !== 1) begin
      n_fail++; $display("FAIL rem_by_zero: result=%h lat=%0d want fffffffb lat 1", res, lat);
    end
    do_op(OP_DIV, -32'sd5, 32'd0, res, lat, dc, ba, be);
    n_checks++;
    if (res !== 32'hFFFF_FFFF || lat !== 1) begin
      n_fail++; $display("FAIL div_by_zero: result=%h lat=%0d want ffffffff lat 1", res, lat);
    end
  endtask

  task automatic test_overflow;
    logic [N-1:0] res;
    int lat, dc;
    logic ba, be;
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, dc, ba, be);
    n_checks++;
    if (res !== 32'h8000_0000 || lat !== 1) begin
      n_fail++; $display("FAIL div_overflow: result=%h lat=%0d want 80000000 lat 1", res, lat);
    end
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, dc, ba, be);
    n_checks++;
    if (res !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL rem_overflow: result=%h lat=%0d want 00000000 lat 1", res, lat);
    end
    // Unsigned: 2^31 / (2^32-1) = 0 remainder 2^31, through the full path.
    do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, dc, ba, be);
    n_checks++;
    if (res !== 32'h0 || lat !== N + 1) begin
      n_fail++; $display("FAIL divu_big: result=%h lat=%0d want 00000000 lat %0d", res, lat, N + 1);
    end
    do_op(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, dc, ba, be);
    n_checks++;
    if (res !== 32'h8000_0000 || lat !== N + 1) begin
      n_fail++; $display("FAIL remu_big: result=%h lat=%0d want 80000000 lat %0d", res, lat, N + 1);
    end
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, res, lat, dc, ba, be);
    n_checks++;
    if (res !== 32'd1 || lat !== N + 1) begin
      n_fail++; $display("FAIL divu_max: result=%h lat=%0d want 00000001 lat %0d", res, lat, N + 1);
    end
  endtask

  task automatic test_start_ignored;
    int d_first, dc;
    logic [N-1:0] res;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    d_first = -1; dc = 0; res = 'x;
    for (int i = 1; i <= 45; i++) begin
      if (i == 6) begin
        @(negedge clk);
        start = 1'b1; op = OP_DIV; dividend = 32'd1000; divisor = 32'd3;
      end
      if (i == 7) begin
        @(negedge clk);
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        if (d_first < 0) begin d_first = i; res = result; end
        dc++;
      end
    end
    n_checks++;
    if (res !== 32'd14 || d_first !== N + 1 || dc !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_calc: result=%h lat=%0d done=%0d busy=%b want 0000000e lat %0d done 1 busy 0",
               res, d_first, dc, busy, N + 1);
    end
  endtask

  task automatic test_back_to_back;
    int d1, d2, unstable;
    logic [N-1:0] r1, r2;
    logic b_idle, b_acc;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    dividend = 32'd200;  // start stays high; new operands are for the second request
    d1 = -1; d2 = -1; unstable = 0; r1 = 'x; r2 = 'x; b_idle = 1'bx; b_acc = 1'bx;
    for (int e = 1; e <= 75; e++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 < 0) begin d1 = e; r1 = result; end
        else if (d2 < 0) begin d2 = e; r2 = result; end
      end
      if (e == N + 2) b_idle = busy;
      if (e == N + 3) begin
        b_acc = busy;
        start = 1'b0;
      end
      if (e >= N + 2 && e <= 2 * N + 3 && result !== 32'd14) unstable++;
    end
    n_checks++;
    if (r1 !== 32'd14 || d1 !== N + 1) begin
      n_fail++; $display("FAIL b2b_first: result=%h lat=%0d want 0000000e lat %0d", r1, d1, N + 1);
    end
    n_checks++;
    if (b_idle !== 1'b0 || b_acc !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept_edge: busy_idle=%b busy_acc=%b want 0 1", b_idle, b_acc);
    end
    n_checks++;
    if (unstable !== 0) begin
      n_fail++; $display("FAIL b2b_result_hold: changed cycles=%0d want 0", unstable);
    end
    n_checks++;
    if (r2 !== 32'd28 || d2 !== 2 * N + 4) begin
      n_fail++; $display("FAIL b2b_second: result=%h at edge %0d want 0000001c at edge %0d", r2, d2, 2 * N + 4);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_divu();
    test_reset_abort();
    test_signed();
    test_div_zero();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
